// File: rtl/input_port_controller.sv
// input_port_controller: buffers flits, captures the head for routing, requests the allocator and forwards the granted packet
module input_port_controller #(
  parameter int N = 4,
  parameter int DATA_WIDTH = 8,
  parameter int PhitPerFlit = 2,
  parameter int REQUEST_WIDTH = 2,
  parameter int BUFFER_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [PhitPerFlit*DATA_WIDTH-1:0] in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [PhitPerFlit*DATA_WIDTH-1:0] head_flit,
  input  logic [REQUEST_WIDTH-1:0]          route_request,
  output logic [REQUEST_WIDTH-1:0]          request,
  output logic                              request_valid,
  input  logic                              grant,
  output logic [PhitPerFlit*DATA_WIDTH-1:0] out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              protocol_error
);
  localparam int FW = PhitPerFlit * DATA_WIDTH;
  localparam int AW = $clog2(BUFFER_DEPTH);
  if (BUFFER_DEPTH < 2 || (BUFFER_DEPTH & (BUFFER_DEPTH - 1)) != 0 || N < 2) begin : g_bad_params
    $error("input_port_controller: bad parameters");
  end
  typedef enum logic [1:0] {IDLE, ROUTE, WAIT_GRANT, FORWARD} state_t;
  state_t state, state_nxt;
  logic [FW-1:0] mem [BUFFER_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [FW-1:0] front;
  logic empty, push, pop;
  assign front = mem[rd_ptr];
  assign empty = count == '0;
  assign in_ready = rst && count != (AW+1)'(BUFFER_DEPTH);
  assign push = in_valid && in_ready;
  assign out_valid = state == FORWARD && grant && !empty;
  assign out_data = front;
  assign pop = (out_valid && out_ready) || (state == IDLE && !empty && !front[FW-2]);
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= in_data;
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      state  <= IDLE;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + (AW+1)'(push) - (AW+1)'(pop);
      state  <= state_nxt;
    end
  end
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE       ? ((!empty && front[FW-2]) ? ROUTE : IDLE) :
                state == ROUTE      ? WAIT_GRANT :
                state == WAIT_GRANT ? (grant ? FORWARD : WAIT_GRANT) :
                                      ((pop && front[FW-1]) ? IDLE : FORWARD);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_flit      <= '0;
      request        <= '0;
      request_valid  <= 1'b0;
      protocol_error <= 1'b0;
    end else begin
      if (state == IDLE && !empty && front[FW-2]) head_flit <= front;
      if (state == ROUTE) begin
        request       <= route_request;
        request_valid <= 1'b1;
      end
      if (state == FORWARD && pop && front[FW-1]) request_valid <= 1'b0;
      if (state == IDLE && pop) protocol_error <= 1'b1;
    end
  end
endmodule
